// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus arbiter: FSM states and HD44780-style command words.
package lcd_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    SETTLE    = 2'd2,
    ACK       = 2'd3
  } busState_t;

  // {RS, byte} pairs, ready to be split onto a requester's data/RS lanes
  localparam logic [8:0] FUNC_SET = 9'h038;
  localparam logic [8:0] DISP_ON  = 9'h00C;
  localparam logic [8:0] CLEAR    = 9'h001;
  localparam logic [8:0] ENTRY    = 9'h006;
  localparam logic [8:0] LINE1    = 9'h080;
  localparam logic [8:0] LINE2    = 9'h0C0;
  localparam logic [8:0] SP       = 9'h120;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: rotate requests by the pointer, take the lowest set bit,
// rotate back. A requesting lock owner overrides the rotation.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] pointer,
  input  logic [NREQ-1:0]  lock,
  output logic [NREQ-1:0]  winner
);

  logic [NREQ-1:0] rot;
  logic [NREQ-1:0] pick;
  logic [NREQ-1:0] rotBack;
  logic [NREQ-1:0] lockReq;

  always_comb begin
    rot     = NREQ'({req, req} >> pointer);
    pick    = rot & (~rot + NREQ'(1));
    rotBack = NREQ'(({pick, pick} << pointer) >> NREQ);
    lockReq = lock & req;
    winner  = (|lockReq) ? lockReq : rotBack;
  end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Shares one LCD_Controller byte-writer between NREQ requesters: round-robin with optional
// burst lock, start/done handshake with timeout, settle delay, then ack to the owner.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int               NREQ    = 2,
  parameter int               DLY_W   = 18,
  parameter logic [DLY_W-1:0] DLY_MAX = 18'h3FFFE,
  parameter int               TMO_W   = 20
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [NREQ-1:0]   iREQ,
  input  logic [8*NREQ-1:0] iREQ_DATA,
  input  logic [NREQ-1:0]   iREQ_RS,
  input  logic [NREQ-1:0]   iREQ_LOCK,
  output logic [NREQ-1:0]   oGRANT,
  output logic [NREQ-1:0]   oACK,
  output logic              oERR,
  output logic              oBUSY,
  output logic [7:0]        oLCD_DATA,
  output logic              oLCD_RS,
  output logic              oLCD_Start,
  input  logic              iLCD_Done
);

  localparam int PTR_W = (NREQ > 2) ? 2 : 1;

  busState_t        state;
  logic [PTR_W-1:0] rrPtr;
  logic [NREQ-1:0]  lockOwner;
  logic [DLY_W-1:0] dlyCnt;
  logic [TMO_W-1:0] tmoCnt;

  logic [NREQ-1:0]  winner;
  logic [PTR_W-1:0] winIdx;
  logic [PTR_W-1:0] nextPtr;
  logic [7:0]       winData;
  logic             winRs;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) uArb (
    .req     (iREQ),
    .pointer (rrPtr),
    .lock    (lockOwner),
    .winner  (winner)
  );

  always_comb begin
    winIdx  = '0;
    winData = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (winner[i]) begin
        winIdx  = PTR_W'(i);
        winData = iREQ_DATA[8*i +: 8];
      end
    end
    winRs   = |(iREQ_RS & winner);
    nextPtr = (winIdx == PTR_W'(NREQ - 1)) ? '0 : winIdx + 1'b1;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= IDLE;
      rrPtr      <= '0;
      lockOwner  <= '0;
      dlyCnt     <= '0;
      tmoCnt     <= '0;
      oGRANT     <= '0;
      oACK       <= '0;
      oERR       <= 1'b0;
      oBUSY      <= 1'b0;
      oLCD_DATA  <= '0;
      oLCD_RS    <= 1'b0;
      oLCD_Start <= 1'b0;
    end else begin
      oACK <= '0;
      oERR <= 1'b0;
      case (state)
        IDLE: begin
          // a silent lock owner gives up the lock; the arbiter already fell back to rr
          if ((lockOwner & iREQ) == '0) lockOwner <= '0;
          if (|iREQ) begin
            oGRANT     <= winner;
            oLCD_DATA  <= winData;
            oLCD_RS    <= winRs;
            oLCD_Start <= 1'b1;
            oBUSY      <= 1'b1;
            rrPtr      <= nextPtr;
            tmoCnt     <= '0;
            state      <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (iLCD_Done) begin
            oLCD_Start <= 1'b0;
            tmoCnt     <= '0;
            state      <= SETTLE;
          end else if (tmoCnt == '1) begin
            oLCD_Start <= 1'b0;
            oERR       <= 1'b1;
            tmoCnt     <= '0;
            state      <= SETTLE;
          end else begin
            tmoCnt <= tmoCnt + 1'b1;
          end
        end
        SETTLE: begin
          if (dlyCnt == DLY_MAX) begin
            dlyCnt <= '0;
            // registered here so the pulse is visible while in ACK
            oACK   <= oGRANT;
            state  <= ACK;
          end else begin
            dlyCnt <= dlyCnt + 1'b1;
          end
        end
        ACK: begin
          lockOwner <= (|(iREQ_LOCK & oGRANT)) ? oGRANT : '0;
          oGRANT    <= '0;
          oBUSY     <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
